// File: rtl/adc_capture.sv
// adc_capture: ADC capture pipeline with decimation, output formatting and overrange tracking.
// Define ADC_PEAK_EN to compile in the peak-hold logic.
module adc_capture #(
    parameter int DATA_W = 12,
    parameter int DELAY  = 3,
    parameter int DEC_W  = 8
) (
    input  logic              clk_sample,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ovr_in,
    input  logic              en,
    input  logic              fmt_twos,
    input  logic [DEC_W-1:0]  dec_ratio,
    input  logic              ovr_clr,
    input  logic              peak_clr,
    output logic              adc_clk,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              ovr_out,
    output logic              ovr_flag,
    output logic [DATA_W-1:0] peak_out
);
    logic [DEC_W-1:0]  dec_cnt;
    logic [DEC_W-1:0]  eff_ratio;
    logic              tag_in;
    logic              arr_tag;
    logic              arr_ovr;
    logic [DATA_W-1:0] arr_data;
    logic [DATA_W-1:0] fmt_data;

    assign adc_clk   = ~clk_sample;
    assign eff_ratio = (dec_ratio == '0) ? DEC_W'(1) : dec_ratio;
    assign tag_in    = en && (dec_cnt == '0);
    assign fmt_data  = arr_data ^ {fmt_twos, {(DATA_W-1){1'b0}}};

    // >= rather than == so a mid-run ratio reduction wraps immediately
    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n)
            dec_cnt <= '0;
        else if (!en || dec_cnt >= eff_ratio - DEC_W'(1))
            dec_cnt <= '0;
        else
            dec_cnt <= dec_cnt + DEC_W'(1);
    end

    generate
        if (DELAY > 1) begin : g_pipe
            logic [DATA_W+1:0] pipe [DELAY-1];
            always_ff @(posedge clk_sample or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DELAY-1; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= {tag_in, ovr_in, data_in};
                    for (int i = 1; i < DELAY-1; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign {arr_tag, arr_ovr, arr_data} = pipe[DELAY-2];
        end else begin : g_direct
            assign {arr_tag, arr_ovr, arr_data} = {tag_in, ovr_in, data_in};
        end
    endgenerate

    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            ovr_out    <= 1'b0;
            ovr_flag   <= 1'b0;
        end else begin
            data_valid <= arr_tag;
            if (arr_tag) begin
                data_out <= fmt_data;
                ovr_out  <= arr_ovr;
            end
            ovr_flag <= (arr_tag && arr_ovr) || (ovr_flag && !ovr_clr);
        end
    end

`ifdef ADC_PEAK_EN
    logic peak_empty;
    logic peak_gt;

    assign peak_gt = fmt_twos ? ($signed(fmt_data) > $signed(peak_out)) : (fmt_data > peak_out);

    always_ff @(posedge clk_sample or negedge rst_n) begin
        if (!rst_n) begin
            peak_out   <= '0;
            peak_empty <= 1'b1;
        end else if (arr_tag) begin
            if (peak_empty || peak_clr || peak_gt) peak_out <= fmt_data;
            peak_empty <= 1'b0;
        end else if (peak_clr) begin
            peak_empty <= 1'b1;
        end
    end
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_out = '0;
`endif
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed plus random stimulus for adc_capture, checked against a queue-based model.
module tb_adc_capture;
    localparam int W  = 12;
    localparam int D  = 3;
    localparam int DW = 8;

    logic          clk_sample = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          ovr_in = 1'b0;
    logic          en = 1'b1;
    logic          fmt_twos = 1'b0;
    logic [DW-1:0] dec_ratio = 8'd1;
    logic          ovr_clr = 1'b0;
    logic          peak_clr = 1'b0;
    logic          adc_clk;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          ovr_out;
    logic          ovr_flag;
    logic [W-1:0]  peak_out;

    adc_capture #(.DATA_W(W), .DELAY(D), .DEC_W(DW)) dut (
        .clk_sample(clk_sample), .rst_n(rst_n), .data_in(data_in), .ovr_in(ovr_in),
        .en(en), .fmt_twos(fmt_twos), .dec_ratio(dec_ratio), .ovr_clr(ovr_clr),
        .peak_clr(peak_clr), .adc_clk(adc_clk), .data_out(data_out),
        .data_valid(data_valid), .ovr_out(ovr_out), .ovr_flag(ovr_flag), .peak_out(peak_out)
    );

    always #5 clk_sample = ~clk_sample;

    int n_assert = 0;
    int n_fail = 0;

    // history of captured samples {tag, ovr, data}, one entry per clock edge
    logic [W+1:0] hist[$];
    int           phase;
    logic [W-1:0] m_data, m_peak;
    logic         m_valid, m_ovr, m_flag, m_empty;

    function automatic logic [W-1:0] fmt(logic [W-1:0] d, logic t);
        return t ? W'((int'(d) + 2**(W-1)) % 2**W) : d;
    endfunction

    function automatic int sval(logic [W-1:0] v);
        return (int'(v) >= 2**(W-1)) ? int'(v) - 2**W : int'(v);
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        phase = 0;
        m_data = '0; m_peak = '0;
        m_valid = 1'b0; m_ovr = 1'b0; m_flag = 1'b0; m_empty = 1'b1;
    endtask

    task automatic model_edge();
        int eff;
        logic tag;
        logic [W+1:0] rec;
        eff = (dec_ratio == 0) ? 1 : int'(dec_ratio);
        tag = en && (phase == 0);
        phase = en ? ((phase + 1 >= eff) ? 0 : phase + 1) : 0;
        hist.push_back({tag, ovr_in, data_in});
        m_valid = 1'b0;
        if (hist.size() >= D) begin
            rec = hist[hist.size()-D];
            if (rec[W+1]) begin
                m_valid = 1'b1;
                m_data = fmt(rec[W-1:0], fmt_twos);
                m_ovr = rec[W];
            end
        end
        m_flag = (m_valid && m_ovr) ? 1'b1 : (ovr_clr ? 1'b0 : m_flag);
`ifdef ADC_PEAK_EN
        if (m_valid) begin
            if (m_empty || peak_clr || (fmt_twos ? sval(m_data) > sval(m_peak) : m_data > m_peak))
                m_peak = m_data;
            m_empty = 1'b0;
        end else if (peak_clr) begin
            m_empty = 1'b1;
        end
`endif
        while (hist.size() > D) void'(hist.pop_front());
    endtask

    task automatic check_all();
        chk("data_valid", data_valid, m_valid);
        chk("data_out", data_out, m_data);
        chk("ovr_out", ovr_out, m_ovr);
        chk("ovr_flag", ovr_flag, m_flag);
        chk("peak_out", peak_out, m_peak);
        chk("adc_clk", adc_clk, 0);
    endtask

    task automatic step();
        @(posedge clk_sample);
        if (!rst_n) model_reset();
        else model_edge();
        #1 check_all();
    endtask

    initial begin
        model_reset();
        // reset held with live ramp input
        for (int k = 0; k < 2; k++) begin
            data_in = W'(k);
            step();
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = W'(k);
            step();
        end
        chk("ramp_latency", data_out, 7);
        // two's complement conversion
        fmt_twos = 1'b1;
        data_in = 12'h800; step();
        data_in = 12'hFFF; step();
        data_in = 12'h000; step();
        chk("twos_800", data_out, 12'h000);
        step();
        chk("twos_fff", data_out, 12'h7FF);
        step();
        chk("twos_000", data_out, 12'h800);
        fmt_twos = 1'b0;
        // decimation 4 then 2 mid-run
        dec_ratio = 8'd4;
        for (int k = 0; k < 16; k++) begin
            data_in = W'(k);
            step();
        end
        dec_ratio = 8'd2;
        for (int k = 16; k < 24; k++) begin
            data_in = W'(k);
            step();
        end
        dec_ratio = 8'd1;
        // overrange pulse, sticky flag, clear priority
        ovr_in = 1'b1; step();
        ovr_in = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("ovr_sticky", ovr_flag, 1);
        ovr_in = 1'b1; step();
        ovr_in = 1'b0; step();
        ovr_clr = 1'b1; step();
        chk("ovr_set_wins", ovr_flag, 1);
        step();
        chk("ovr_cleared", ovr_flag, 0);
        ovr_clr = 1'b0;
        // drop enable with samples in flight
        for (int k = 0; k < 3; k++) begin
            data_in = W'(12'h100 + k);
            step();
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            data_in = W'($urandom);
            step();
        end
        chk("en_drain_hold", data_out, 12'h102);
        en = 1'b1;
        // peak hold: outputs 100, F00, 300 in two's complement, then restart with 900
        fmt_twos = 1'b1;
        peak_clr = 1'b1; en = 1'b0; step();
        peak_clr = 1'b0; en = 1'b1;
        data_in = 12'h900; step();
        data_in = 12'h700; step();
        data_in = 12'hB00; step();
        en = 1'b0;
        step(); step(); step();
`ifdef ADC_PEAK_EN
        chk("peak_max", peak_out, 12'h300);
`endif
        peak_clr = 1'b1; step();
        peak_clr = 1'b0; en = 1'b1;
        data_in = 12'h100; step();
        en = 1'b0;
        step(); step();
`ifdef ADC_PEAK_EN
        chk("peak_restart", peak_out, 12'h900);
`endif
        // randomized stream with a mid-stream reset
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) fmt_twos = 1'($urandom);
            if (i % 40 == 0) dec_ratio = DW'($urandom_range(0, 5));
            en = ($urandom_range(0, 9) != 0);
            data_in = W'($urandom);
            ovr_in = ($urandom_range(0, 7) == 0);
            ovr_clr = ($urandom_range(0, 5) == 0);
            peak_clr = ($urandom_range(0, 15) == 0);
            if (i == 150) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_data_out", data_out, 0);
                chk("rst_valid", data_valid, 0);
                chk("rst_ovr_flag", ovr_flag, 0);
                chk("rst_peak", peak_out, 0);
                model_reset();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_capture.md
# adc_capture

Parametrised ADC front-end capture stage for the parallel-output ADC family. It registers raw converter words on clk_sample through a configurable alignment pipeline and optionally decimates them. Output formatting is selectable between offset-binary and two's complement, and converter overrange is tracked per sample and as a sticky flag. It sits between the ADC pins and downstream DSP/DAC logic, and supplies the inverted converter clock.

## Interface
- DATA_W, 12: converter word width (2..16).
- DELAY, 3: capture pipeline depth in register stages (1..8).
- DEC_W, 8: width of decimation ratio input.
- clk_sample  in  1  sample clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_W  raw ADC word, offset-binary.
- ovr_in  in  1  ADC overrange pin, same timing as data_in.
- en  in  1  capture enable; low = no new valid samples.
- fmt_twos  in  1  1 = two's complement output, 0 = offset-binary passthrough.
- dec_ratio  in  DEC_W  keep 1 of every dec_ratio samples; 0 treated as 1.
- ovr_clr  in  1  clears ovr_flag.
- adc_clk  out  1  converter clock = ~clk_sample (combinational, unaffected by reset).
- data_out  out  DATA_W  formatted sample, held between valid strobes.
- data_valid  out  1  one-cycle strobe, data_out updated this cycle.
- ovr_out  out  1  overrange bit aligned with data_out.
- ovr_flag  out  1  sticky overrange.
- peak_out  out  DATA_W  peak hold (ADC_PEAK_EN only).
- peak_clr  in  1  restarts peak hold (ADC_PEAK_EN only).

## Operation
- Reset: all pipeline stages, valid tags, dec counter, data_out, data_valid, ovr_out, ovr_flag, peak_out = 0.
- Decimation counter dec_cnt (DEC_W bits): while en=1, input sample tagged valid when dec_cnt==0. dec_cnt increments, wraps to 0 when dec_cnt >= eff_ratio-1 (eff_ratio = max(dec_ratio,1)). A mid-run reduction of dec_ratio therefore wraps on the next edge, never overruns.
- en=0: dec_cnt forced to 0, new samples tagged invalid. In-flight valid samples still drain to output.
- Pipeline: {data, ovr, tag} shift through stages 1..DELAY-1 every edge. Output stage loads only when the arriving tag is 1.
- Format at output load: fmt_twos=1 inverts MSB of data; fmt_twos=0 passes data unchanged. fmt_twos is sampled at load time.
- data_valid = registered tag of output stage. data_out and ovr_out hold their last values when no valid sample arrives.
- ovr_flag: set on any valid output with ovr bit = 1, cleared by ovr_clr. Simultaneous set and clear: set wins.

## Timing
- Sample captured at edge n, with tag 1: appears on data_out and data_valid after edge n+DELAY-1 (DELAY register stages total). DELAY=1: output stage is the capture register.
- Throughput: 1 sample/cycle at eff_ratio=1. With eff_ratio=R, data_valid is high exactly 1 of every R cycles in steady state.
- en rising at edge n: first tagged sample is the one captured at edge n.
- ovr_flag updates on the same edge as the data_valid it reflects. ovr_clr takes effect on the next edge.
- Reset asserted mid-stream discards in-flight samples immediately. The first valid sample after release follows full latency.

## Configuration
- ADC_PEAK_EN defined: peak hold is compiled in. An internal empty bit is set at reset and by peak_clr. The next valid output loads peak_out directly. Subsequent valid outputs replace peak_out when greater: signed compare if fmt_twos=1, unsigned if 0. peak_clr coincident with a valid output: that sample loads peak_out and empty clears.
- ADC_PEAK_EN undefined: no peak logic. peak_out is tied to 0 and peak_clr is ignored.

## Test plan
- Reset, DELAY=3, dec_ratio=1, en=1, ramp 0,1,2…: data_out=0 and data_valid=0 during reset. Sample k appears 2 edges after the edge that captured it, with data_valid continuously high.
- fmt_twos=1, data_in=12'h800 then 12'hFFF then 12'h000: data_out=12'h000, 12'h7FF, 12'h800.
- dec_ratio=4 with ramp input: data_valid every 4th cycle carrying samples 0,4,8…. Changing to 2 mid-run gives no missed or extra strobe beyond one short interval.
- ovr_in pulsed with one valid sample: ovr_out=1 on that output only and ovr_flag stays 1. ovr_clr together with a new overrange output leaves ovr_flag=1. ovr_clr alone clears it.
- en dropped with 2 samples in flight: both still emerge, then data_valid stays 0 and data_out holds. rst_n pulsed mid-stream: all outputs 0 immediately.
- ADC_PEAK_EN, fmt_twos=1, samples 12'h100, 12'hF00, 12'h300: peak_out=12'h300 after the last. peak_clr then sample 12'h900 gives peak_out=12'h900.
